// File: rtl/multi_cycle_ctrl.sv
// Control FSM for a multi-cycle CPU: sequences IF/ID/EXE/MEM/WB and drives datapath selects/enables.
// Optional MEM_WAIT_EN: MEM stalls until mem_ready, holding the memory strobe.
module multi_cycle_ctrl #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              PCWre,
  output logic              IRWre,
  output logic [1:0]        PCSrc,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              ExtSel,
  output logic [1:0]        RegDst,
  output logic              WrRegDSrc,
  output logic              DBDataSrc,
  output logic              RegWre,
  output logic              mRD,
  output logic              mWR,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_BR = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
  localparam logic [OPW-1:0] OP_OR   = 6'b010000;
  localparam logic [OPW-1:0] OP_AND  = 6'b010001;
  localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
  localparam logic [OPW-1:0] OP_SLL  = 6'b011000;
  localparam logic [OPW-1:0] OP_SLT  = 6'b100111;
  localparam logic [OPW-1:0] OP_SW   = 6'b110000;
  localparam logic [OPW-1:0] OP_LW   = 6'b110001;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OPW-1:0] OP_J    = 6'b111000;
  localparam logic [OPW-1:0] OP_JR   = 6'b111001;
  localparam logic [OPW-1:0] OP_JAL  = 6'b111010;
  localparam logic [OPW-1:0] OP_HALT = 6'b111111;

  localparam logic [ALUOPW-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOPW-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOPW-1:0] ALU_SLL = 3'b010;
  localparam logic [ALUOPW-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOPW-1:0] ALU_AND = 3'b100;
  localparam logic [ALUOPW-1:0] ALU_SLT = 3'b110;

  state_e state_q, state_d;

  logic is_rtype, is_alui, is_ls;
  logic pcwre_raw, irwre_raw, regwre_raw, mrd_raw, mwr_raw;
  logic mem_go;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR) ||
                    (opcode == OP_AND) || (opcode == OP_SLL) || (opcode == OP_SLT);
  assign is_alui  = (opcode == OP_ADDI) || (opcode == OP_ORI);
  assign is_ls    = (opcode == OP_LW) || (opcode == OP_SW);

`ifdef MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_go = 1'b1;
`endif

  // Operand/ALU selects decode straight from the IR opcode, which is stable for
  // the whole instruction, so they naturally hold from EXE through MEM/WB.
  always_comb begin
    ALUOp = ALU_ADD;
    unique case (opcode)
      OP_SUB, OP_BEQ: ALUOp = ALU_SUB;
      OP_SLL:         ALUOp = ALU_SLL;
      OP_OR, OP_ORI:  ALUOp = ALU_OR;
      OP_AND:         ALUOp = ALU_AND;
      OP_SLT:         ALUOp = ALU_SLT;
      default:        ALUOp = ALU_ADD;
    endcase
    ALUSrcA   = (opcode == OP_SLL);
    ALUSrcB   = is_alui || is_ls;
    ExtSel    = (opcode == OP_ADDI) || is_ls || (opcode == OP_BEQ);
    RegDst    = (opcode == OP_JAL) ? 2'b00 : (is_rtype ? 2'b10 : 2'b01);
    WrRegDSrc = (opcode != OP_JAL);
    DBDataSrc = (opcode == OP_LW);
  end

  always_comb begin
    state_d    = state_q;
    pcwre_raw  = 1'b0;
    irwre_raw  = 1'b0;
    regwre_raw = 1'b0;
    mrd_raw    = 1'b0;
    mwr_raw    = 1'b0;
    PCSrc      = 2'b00;
    unique case (state_q)
      S_IF: begin
        irwre_raw = 1'b1;
        state_d   = S_ID;
      end
      S_ID: begin
        if (opcode == OP_J || opcode == OP_JAL) begin
          pcwre_raw  = 1'b1;
          PCSrc      = 2'b11;
          regwre_raw = (opcode == OP_JAL);
          state_d    = S_IF;
        end else if (opcode == OP_JR) begin
          pcwre_raw = 1'b1;
          PCSrc     = 2'b10;
          state_d   = S_IF;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (opcode == OP_BEQ) begin
          state_d = S_EXE_BR;
        end else if (is_ls) begin
          state_d = S_EXE_LS;
        end else if (is_rtype || is_alui) begin
          state_d = S_EXE_AL;
        end else begin
          // Undefined opcode retires as a NOP.
          pcwre_raw = 1'b1;
          state_d   = S_IF;
        end
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_BR: begin
        pcwre_raw = 1'b1;
        PCSrc     = zero ? 2'b01 : 2'b00;
        state_d   = S_IF;
      end
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        if (opcode == OP_LW) begin
          mrd_raw = 1'b1;
          if (mem_go) state_d = S_WB_LD;
        end else begin
          mwr_raw = (opcode == OP_SW);
          if (mem_go) begin
            pcwre_raw = 1'b1;
            state_d   = S_IF;
          end
        end
      end
      S_WB_AL, S_WB_LD: begin
        regwre_raw = 1'b1;
        pcwre_raw  = 1'b1;
        state_d    = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Enables are gated by reset so nothing fires while RST_n is low, even though
  // the state register already reads IF.
  assign PCWre  = pcwre_raw  & RST_n;
  assign IRWre  = irwre_raw  & RST_n;
  assign RegWre = regwre_raw & RST_n;
  assign mRD    = mrd_raw    & RST_n;
  assign mWR    = mwr_raw    & RST_n;
  assign state  = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class through its states.
module tb_multi_cycle_ctrl;
  logic       CLK = 1'b0;
  logic       RST_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;
  int pc_cnt = 0;
  int pc_base;

  multi_cycle_ctrl dut (
    .CLK(CLK), .RST_n(RST_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ExtSel(ExtSel), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .state(state)
  );

  always #5 CLK = ~CLK;

  // Each state lasts one full cycle, so sampling on negedge counts each pulse once.
  always @(negedge CLK) if (PCWre === 1'b1) pc_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Run IF and ID checks, leaving the DUT in the state after ID.
  task automatic fetch(input logic [5:0] op);
    opcode = op;
    chk("if_state", 32'(state), 32'd0);
    chk("if_irwre", 32'(IRWre), 32'd1);
    tick();
    chk("id_state", 32'(state), 32'd1);
    chk("id_irwre", 32'(IRWre), 32'd0);
  endtask

  initial begin
    RST_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_irwre", 32'(IRWre), 32'd0);
    chk("rst_pcwre", 32'(PCWre), 32'd0);
    tick(); tick();
    RST_n = 1'b1;
    #1;

    // add: IF, ID, EXE_AL, WB_AL
    pc_base = pc_cnt;
    fetch(6'b000000);
    chk("add_id_pcwre", 32'(PCWre), 32'd0);
    tick();
    chk("add_exe_state", 32'(state), 32'd2);
    chk("add_exe_aluop", 32'(ALUOp), 32'd0);
    chk("add_exe_srcb", 32'(ALUSrcB), 32'd0);
    tick();
    chk("add_wb_state", 32'(state), 32'd6);
    chk("add_wb_regwre", 32'(RegWre), 32'd1);
    chk("add_wb_regdst", 32'(RegDst), 32'd2);
    chk("add_wb_wrsrc", 32'(WrRegDSrc), 32'd1);
    chk("add_wb_dbsrc", 32'(DBDataSrc), 32'd0);
    chk("add_wb_pcwre", 32'(PCWre), 32'd1);
    chk("add_wb_pcsrc", 32'(PCSrc), 32'd0);
    tick();
    chk("add_pc_once", 32'(pc_cnt - pc_base), 32'd1);

    // sll: shamt operand
    fetch(6'b011000);
    tick();
    chk("sll_srca", 32'(ALUSrcA), 32'd1);
    chk("sll_aluop", 32'(ALUOp), 32'd2);
    tick(); tick();

    // ori: zero-extended immediate, rt destination
    fetch(6'b010010);
    tick();
    chk("ori_srcb", 32'(ALUSrcB), 32'd1);
    chk("ori_ext", 32'(ExtSel), 32'd0);
    chk("ori_aluop", 32'(ALUOp), 32'd3);
    tick();
    chk("ori_wb_regdst", 32'(RegDst), 32'd1);
    chk("ori_wb_srcb_held", 32'(ALUSrcB), 32'd1);
    tick();

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      pc_base = pc_cnt;
      fetch(6'b110100);
      tick();
      chk("beq_state", 32'(state), 32'd3);
      chk("beq_aluop", 32'(ALUOp), 32'd1);
      chk("beq_srcb", 32'(ALUSrcB), 32'd0);
      chk("beq_pcwre", 32'(PCWre), 32'd1);
      chk("beq_pcsrc", 32'(PCSrc), z ? 32'd1 : 32'd0);
      tick();
      chk("beq_back_if", 32'(state), 32'd0);
      chk("beq_pc_once", 32'(pc_cnt - pc_base), 32'd1);
    end

    // lw: 5 cycles
    pc_base = pc_cnt;
    fetch(6'b110001);
    tick();
    chk("lw_exe_state", 32'(state), 32'd4);
    chk("lw_exe_srcb", 32'(ALUSrcB), 32'd1);
    chk("lw_exe_ext", 32'(ExtSel), 32'd1);
    tick();
    chk("lw_mem_state", 32'(state), 32'd5);
    chk("lw_mem_mrd", 32'(mRD), 32'd1);
    chk("lw_mem_pcwre", 32'(PCWre), 32'd0);
    tick();
    chk("lw_wb_state", 32'(state), 32'd7);
    chk("lw_wb_dbsrc", 32'(DBDataSrc), 32'd1);
    chk("lw_wb_regdst", 32'(RegDst), 32'd1);
    chk("lw_wb_regwre", 32'(RegWre), 32'd1);
    chk("lw_wb_mrd", 32'(mRD), 32'd0);
    tick();
    chk("lw_back_if", 32'(state), 32'd0);
    chk("lw_pc_once", 32'(pc_cnt - pc_base), 32'd1);

    // sw: 4 cycles
    pc_base = pc_cnt;
    fetch(6'b110000);
    tick();
    tick();
    chk("sw_mem_state", 32'(state), 32'd5);
    chk("sw_mem_mwr", 32'(mWR), 32'd1);
    chk("sw_mem_pcwre", 32'(PCWre), 32'd1);
    chk("sw_mem_regwre", 32'(RegWre), 32'd0);
    tick();
    chk("sw_back_if", 32'(state), 32'd0);
    chk("sw_pc_once", 32'(pc_cnt - pc_base), 32'd1);

    // jal: 2 cycles
    fetch(6'b111010);
    chk("jal_pcsrc", 32'(PCSrc), 32'd3);
    chk("jal_pcwre", 32'(PCWre), 32'd1);
    chk("jal_regwre", 32'(RegWre), 32'd1);
    chk("jal_regdst", 32'(RegDst), 32'd0);
    chk("jal_wrsrc", 32'(WrRegDSrc), 32'd0);
    tick();
    chk("jal_back_if", 32'(state), 32'd0);

    // jr
    fetch(6'b111001);
    chk("jr_pcsrc", 32'(PCSrc), 32'd2);
    chk("jr_regwre", 32'(RegWre), 32'd0);
    tick();

    // undefined opcode retires as NOP
    fetch(6'b000111);
    chk("nop_pcwre", 32'(PCWre), 32'd1);
    chk("nop_pcsrc", 32'(PCSrc), 32'd0);
    chk("nop_regwre", 32'(RegWre), 32'd0);
    tick();
    chk("nop_back_if", 32'(state), 32'd0);

`ifdef MEM_WAIT_EN
    // lw with memory stalled 3 cycles
    mem_ready = 1'b0;
    fetch(6'b110001);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("wait_state", 32'(state), 32'd5);
      chk("wait_mrd", 32'(mRD), 32'd1);
      chk("wait_pcwre", 32'(PCWre), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("wait_last_state", 32'(state), 32'd5);
    chk("wait_last_mrd", 32'(mRD), 32'd1);
    tick();
    chk("wait_wb_state", 32'(state), 32'd7);
    tick();
`endif

    // reset during MEM of sw aborts without strobes
    fetch(6'b110000);
    tick(); tick();
    chk("abort_pre_mwr", 32'(mWR), 32'd1);
    pc_base = pc_cnt;
    #2 RST_n = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_mwr", 32'(mWR), 32'd0);
    chk("abort_pcwre", 32'(PCWre), 32'd0);
    tick();
    chk("abort_no_pc", 32'(pc_cnt - pc_base), 32'd0);
    chk("abort_irwre", 32'(IRWre), 32'd0);
    RST_n = 1'b1;
    #1;

    // halt parks forever
    fetch(6'b111111);
    chk("halt_id_pcwre", 32'(PCWre), 32'd0);
    tick();
    pc_base = pc_cnt;
    for (int i = 0; i < 4; i++) begin
      chk("halt_state", 32'(state), 32'd8);
      chk("halt_irwre", 32'(IRWre), 32'd0);
      tick();
    end
    chk("halt_no_pc", 32'(pc_cnt - pc_base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
